// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle sequencer for the accumulator CPU.
// Fetches an instruction byte into the IR, walks it through FETCH/EXEC/MEM,
// and opens the write strobes and the PC load for one retire cycle only.

`ifndef CU_DEFINES_SV
`define CU_DEFINES_SV
`define CU_ADD        3'b000
`define CU_STA        3'b001
`define CU_LDA        3'b010
`define CU_JMP        3'b011
`define CU_BAN        3'b100
`define CU_LONG_BEGIN 3'b111
`define CU_CLA        5'b00001
`define CU_COM        5'b00010
`define CU_SHR        5'b00100
`define CU_CSL        5'b01000
`define CU_STOP       5'b10000
`endif

module cpu_seq #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [7:0]       imem_rdata,
   output logic             dmem_req,
   input  logic             dmem_ack,
   output logic [7:0]       ir,
   input  logic             cu_wmem,
   input  logic             cu_wacc,
   output logic             wmem_en,
   output logic             wacc_en,
   output logic             pc_en,
   output logic             halted,
   output logic             busy,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [7:0]       ir_q, ir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             imem_req_q, dmem_req_q, halted_q, busy_q;
   logic             is_mem, is_stop, retire;

   // Opcode class decode from the held instruction register.
   always_comb begin
      is_stop = (ir_q == {`CU_LONG_BEGIN, `CU_STOP});
      is_mem  = (ir_q[7:5] inside {`CU_ADD, `CU_STA, `CU_LDA});
   end

   // Next-state, IR/counter update and single-cycle strobe gating.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d = state_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      retire  = 1'b0;
      wmem_en = 1'b0;
      wacc_en = 1'b0;
      pc_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_stop) begin
               state_d = S_HALT;
            end else if (is_mem) begin
               state_d = S_MEM;
            end else begin
               retire  = 1'b1;
               wacc_en = cu_wacc;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            if (dmem_ack) begin
               retire  = 1'b1;
               wmem_en = cu_wmem;
               wacc_en = cu_wacc;
               state_d = S_FETCH;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (retire) begin
         pc_en = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
      end

      // Reset wins: an ack arriving in the reset cycle must not retire anything.
      if (!rst_n) begin
         wmem_en = 1'b0;
         wacc_en = 1'b0;
         pc_en   = 1'b0;
      end
   end

   // State, IR, counter and state-decoded outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ir_q       <= 8'h00;
         cnt_q      <= '0;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         halted_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         cnt_q      <= cnt_d;
         imem_req_q <= (state_d == S_FETCH);
         dmem_req_q <= (state_d == S_MEM);
         halted_q   <= (state_d == S_HALT);
         busy_q     <= (state_d inside {S_FETCH, S_EXEC, S_MEM});
      end
   end

   assign imem_req  = imem_req_q;
   assign dmem_req  = dmem_req_q;
   assign halted    = halted_q;
   assign busy      = busy_q;
   assign ir        = ir_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: self-checking bench for cpu_seq. A 16-bit and a 2-bit counter
// instance run side by side on the same stimulus; the cu decode is modelled here.

`ifndef CU_DEFINES_SV
`define CU_DEFINES_SV
`define CU_ADD        3'b000
`define CU_STA        3'b001
`define CU_LDA        3'b010
`define CU_JMP        3'b011
`define CU_BAN        3'b100
`define CU_LONG_BEGIN 3'b111
`define CU_CLA        5'b00001
`define CU_COM        5'b00010
`define CU_SHR        5'b00100
`define CU_CSL        5'b01000
`define CU_STOP       5'b10000
`endif

module tb_cpu_seq;

   logic        clk = 1'b0;
   logic        rst_n, start, imem_ack, dmem_ack, cu_wmem, cu_wacc;
   logic [7:0]  imem_rdata;
   logic        imem_req, dmem_req, wmem_en, wacc_en, pc_en, halted, busy;
   logic [7:0]  ir;
   logic [15:0] instr_cnt;
   logic        s_imem_req, s_dmem_req, s_wmem_en, s_wacc_en, s_pc_en, s_halted, s_busy;
   logic [7:0]  s_ir;
   logic [1:0]  s_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   int          model_cnt = 0;
   logic [7:0]  exp_ir = 8'h00;

   localparam logic [7:0] STOP_OP = {`CU_LONG_BEGIN, `CU_STOP};

   always #5 clk = ~clk;

   cpu_seq #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack), .ir(ir),
      .cu_wmem(cu_wmem), .cu_wacc(cu_wacc),
      .wmem_en(wmem_en), .wacc_en(wacc_en), .pc_en(pc_en),
      .halted(halted), .busy(busy), .instr_cnt(instr_cnt)
   );

   cpu_seq #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start),
      .imem_req(s_imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(s_dmem_req), .dmem_ack(dmem_ack), .ir(s_ir),
      .cu_wmem(cu_wmem), .cu_wacc(cu_wacc),
      .wmem_en(s_wmem_en), .wacc_en(s_wacc_en), .pc_en(s_pc_en),
      .halted(s_halted), .busy(s_busy), .instr_cnt(s_cnt)
   );

   // Accumulator-write decode of the cu: loads, adds and the long ALU ops.
   function automatic logic model_wacc(input logic [7:0] op);
      if (op[7:5] == `CU_LDA || op[7:5] == `CU_ADD) return 1'b1;
      if (op[7:5] == `CU_LONG_BEGIN)
         return op[4:0] inside {`CU_CLA, `CU_COM, `CU_SHR, `CU_CSL};
      return 1'b0;
   endfunction

   function automatic logic model_wmem(input logic [7:0] op);
      return op[7:5] == `CU_STA;
   endfunction

   function automatic logic is_mem_op(input logic [7:0] op);
      return op[7:5] inside {`CU_ADD, `CU_STA, `CU_LDA};
   endfunction

   // External cu model, driven by the instruction register of the main instance.
   always_comb begin
      cu_wmem = model_wmem(ir);
      cu_wacc = model_wacc(ir);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compares {imem_req,dmem_req,wmem_en,wacc_en,pc_en,halted,busy} in one go.
   task automatic check_cycle(input string name, input logic [6:0] exp);
      check(name, {25'd0, imem_req, dmem_req, wmem_en, wacc_en, pc_en, halted, busy},
            {25'd0, exp});
   endtask

   task automatic check_counts(input string name);
      check({name, "/cnt"}, instr_cnt, model_cnt);
      check({name, "/sat"}, s_cnt, (model_cnt > 3) ? 3 : model_cnt);
   endtask

   // The two write strobes are mutually exclusive in every cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1) check("wr_excl", {31'd0, wmem_en & wacc_en}, 32'd0);
   end

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_cnt = 0;
      exp_ir = 8'h00;
   endtask

   // Runs one instruction starting from the first FETCH cycle; waits are
   // cycles before each ack. elat is the expected retire cycle (-1: none).
   task automatic run_instr(input logic [7:0] op, input int iw, input int dw,
                            input logic ew, input logic ea, input int elat, input string name);
      int  cyc = 0;
      int  ret_cyc = -1;
      logic mem = is_mem_op(op);
      logic stp = (op == STOP_OP);
      for (int i = 0; i <= iw; i++) begin
         imem_ack   = (i == iw);
         imem_rdata = (i == iw) ? op : 8'($urandom);
         cyc++;
         @(negedge clk);
         check_cycle({name, "/fetch"}, 7'b1000001);
         check({name, "/ir_hold"}, ir, exp_ir);
         if (pc_en) ret_cyc = cyc;
         @(posedge clk);
         #1;
      end
      imem_ack = 1'b0;
      exp_ir   = op;
      cyc++;
      @(negedge clk);
      check({name, "/ir_exec"}, ir, exp_ir);
      if (stp || mem) check_cycle({name, "/exec"}, 7'b0000001);
      else            check_cycle({name, "/exec"}, {3'b000, ea, 3'b101});
      if (pc_en) ret_cyc = cyc;
      @(posedge clk);
      #1;
      if (!stp && !mem) model_cnt++;
      if (mem) begin
         for (int i = 0; i <= dw; i++) begin
            dmem_ack = (i == dw);
            cyc++;
            @(negedge clk);
            check({name, "/ir_mem"}, ir, exp_ir);
            if (i == dw) check_cycle({name, "/mem_ack"}, {2'b01, ew, ea, 3'b101});
            else         check_cycle({name, "/mem_wait"}, 7'b0100001);
            if (pc_en) ret_cyc = cyc;
            @(posedge clk);
            #1;
         end
         dmem_ack = 1'b0;
         model_cnt++;
      end
      check({name, "/retire_cyc"}, ret_cyc, elat);
      check_counts(name);
   endtask

   typedef struct {
      logic [7:0] op;
      int         iw;
      int         dw;
      logic       ew;
      logic       ea;
      int         lat;
      string      name;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [7:0] prog [3];
      logic [9:1] wacc_hist, wmem_hist, pc_hist;
      int         idx;

      vecs[0]  = '{8'h43, 0, 0, 1'b0, 1'b1, 3, "lda_zw"};
      vecs[1]  = '{8'h04, 0, 0, 1'b0, 1'b1, 3, "add_zw"};
      vecs[2]  = '{8'h25, 0, 0, 1'b1, 1'b0, 3, "sta_zw"};
      vecs[3]  = '{8'h04, 2, 3, 1'b0, 1'b1, 8, "add_wait"};
      vecs[4]  = '{8'hE1, 0, 0, 1'b0, 1'b1, 2, "cla"};
      vecs[5]  = '{8'hE2, 0, 0, 1'b0, 1'b1, 2, "com"};
      vecs[6]  = '{8'hE4, 0, 0, 1'b0, 1'b1, 2, "shr"};
      vecs[7]  = '{8'hE8, 0, 0, 1'b0, 1'b1, 2, "csl"};
      vecs[8]  = '{8'h7F, 0, 0, 1'b0, 1'b0, 2, "jmp"};
      vecs[9]  = '{8'h82, 0, 0, 1'b0, 1'b0, 2, "ban"};
      vecs[10] = '{8'h3F, 1, 0, 1'b1, 1'b0, 4, "sta_iw1"};
      vecs[11] = '{8'h43, 0, 2, 1'b0, 1'b1, 5, "lda_dw2"};
      vecs[12] = '{8'h60, 3, 0, 1'b0, 1'b0, 5, "jmp_iw3"};

      // Reset and idle: nothing moves while start stays low.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_cycle("idle", 7'b0000000);
         check("idle/ir", ir, 8'h00);
         check_counts("idle");
         @(posedge clk);
         #1;
      end

      // Zero-wait program lda 03, add 04, sta 05; cycle 1 is the first FETCH.
      prog[0] = 8'h43; prog[1] = 8'h04; prog[2] = 8'h25;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      idx = 0;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         imem_rdata = prog[(idx > 2) ? 2 : idx];
         @(negedge clk);
         if (k == 1) check("start_to_fetch", {31'd0, imem_req}, 32'd1);
         wacc_hist[k] = wacc_en;
         wmem_hist[k] = wmem_en;
         pc_hist[k]   = pc_en;
         if (pc_en) idx++;
         @(posedge clk);
         #1;
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      model_cnt = 3;
      exp_ir = 8'h25;
      check("prog/wacc_cycles", {23'd0, wacc_hist}, {23'd0, 9'b000100100});
      check("prog/wmem_cycles", {23'd0, wmem_hist}, {23'd0, 9'b100000000});
      check("prog/pc_cycles",   {23'd0, pc_hist},   {23'd0, 9'b100100100});
      check_counts("prog");

      // Table vectors, applied back to back.
      foreach (vecs[i])
         run_instr(vecs[i].op, vecs[i].iw, vecs[i].dw, vecs[i].ew, vecs[i].ea,
                   vecs[i].lat, vecs[i].name);

      // Random instructions (anything but stop) with random wait states.
      for (int n = 0; n < 60; n++) begin
         logic [7:0] op;
         int iw, dw;
         do op = 8'($urandom); while (op == STOP_OP);
         iw = $urandom_range(0, 3);
         dw = $urandom_range(0, 3);
         run_instr(op, iw, dw, model_wmem(op), model_wacc(op),
                   iw + 2 + (is_mem_op(op) ? dw + 1 : 0), "rand");
      end

      // Stop: no retire, then halted for good; start is ignored.
      run_instr(STOP_OP, 1, 0, 1'b0, 1'b0, -1, "stop");
      for (int i = 0; i < 4; i++) begin
         start = (i % 2 == 0);
         @(negedge clk);
         check_cycle("halt", 7'b0000010);
         check("halt/ir", ir, STOP_OP);
         check_counts("halt");
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      do_reset();
      @(negedge clk);
      check_cycle("halt_reset", 7'b0000000);
      check("halt_reset/ir", ir, 8'h00);
      check_counts("halt_reset");
      @(posedge clk);
      #1;

      // Reset in the MEM cycle that also carries dmem_ack.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      run_instr(8'h04, 0, 0, 1'b0, 1'b1, 3, "pre_rst");
      imem_ack = 1'b1;
      imem_rdata = 8'h43;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      @(posedge clk);
      #1;
      dmem_ack = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mem/strobes", {29'd0, wmem_en, wacc_en, pc_en}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dmem_ack = 1'b0;
      model_cnt = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_cycle("rst_mem/idle", 7'b0000000);
         check("rst_mem/ir", ir, 8'h00);
         check_counts("rst_mem");
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
